// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Circular-buffer FIFO between the I-cache and the instruction realigner
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_fifo_pkg;
   typedef struct packed {
      logic [31:0] address;
      logic [31:0] instruction;
      logic        branch_predict;
      logic [1:0]  branch_taken;
      logic        page_fault;
   } frontend_fetch_t;
endpackage

module fetch_fifo
   import fetch_fifo_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  frontend_fetch_t          in_entry_i,
   output frontend_fetch_t          fetch_entry_o,
   output logic                     fetch_entry_valid_o,
   input  logic                     fetch_ack_i,
   output logic [$clog2(DEPTH):0]   usage_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   frontend_fetch_t  storage [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] usage;
   logic             push;
   logic             pop;

   // Ready and valid depend only on the occupancy register, never on ack.
   assign in_ready_o          = (usage != FULL_COUNT);
   assign fetch_entry_valid_o = (usage != '0);
   assign fetch_entry_o       = storage[rd_ptr];
   assign usage_o             = usage;

   assign push = in_valid_i  && in_ready_o          && !flush_i;
   assign pop  = fetch_ack_i && fetch_entry_valid_o && !flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         usage  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         usage  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   usage <= usage + 1'b1;
            2'b01:   usage <= usage - 1'b1;
            default: usage <= usage;
         endcase
      end
   end

   // Payload registers carry no reset; validity is tracked by the counter alone.
   always_ff @(posedge clk_i) begin
      if (push) begin
         storage[wr_ptr] <= in_entry_i;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_fifo.sv
// ============================================================================
// Module   : tb_fetch_fifo
// Brief    : Directed self-checking bench for fetch_fifo
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_fifo;
   import fetch_fifo_pkg::*;

   localparam int DEPTH = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   frontend_fetch_t in_entry;
   frontend_fetch_t fetch_entry;
   logic            fetch_valid;
   logic            fetch_ack;
   logic [3:0]      usage;

   int vectors     = 0;
   int miscompares = 0;

   fetch_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .flush_i             (flush),
      .in_valid_i          (in_valid),
      .in_ready_o          (in_ready),
      .in_entry_i          (in_entry),
      .fetch_entry_o       (fetch_entry),
      .fetch_entry_valid_o (fetch_valid),
      .fetch_ack_i         (fetch_ack),
      .usage_o             (usage)
   );

   always #5 clk = ~clk;

   function automatic frontend_fetch_t mk(input logic [31:0] addr, input logic [31:0] instr,
                                          input logic bp, input logic [1:0] bt, input logic pf);
      frontend_fetch_t e;
      e.address        = addr;
      e.instruction    = instr;
      e.branch_predict = bp;
      e.branch_taken   = bt;
      e.page_fault     = pf;
      return e;
   endfunction

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; fetch_ack = 1'b0; in_entry = '0;
      #1;
      vectors++;
      if (usage !== 4'd0) begin miscompares++; $display("FAIL reset_usage got %0d want 0", usage); end
      vectors++;
      if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", fetch_valid); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready); end
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      frontend_fetch_t a;
      a = mk(32'h8000_0000, 32'h0000_0013, 1'b0, 2'b00, 1'b0);
      in_valid = 1'b1; in_entry = a;
      #1;
      vectors++;
      if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL basic_no_fallthrough got %b want 0", fetch_valid); end
      step();
      in_valid = 1'b0;
      vectors++;
      if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", fetch_valid); end
      vectors++;
      if (fetch_entry !== a) begin miscompares++; $display("FAIL basic_entry got %h want %h", fetch_entry, a); end
      vectors++;
      if (usage !== 4'd1) begin miscompares++; $display("FAIL basic_usage got %0d want 1", usage); end
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
      vectors++;
      if (usage !== 4'd0) begin miscompares++; $display("FAIL basic_pop_usage got %0d want 0", usage); end
      vectors++;
      if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pop_valid got %b want 0", fetch_valid); end
      // Ack while empty must not disturb anything.
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
      vectors++;
      if (usage !== 4'd0) begin miscompares++; $display("FAIL basic_empty_ack got %0d want 0", usage); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1;
         in_entry = mk(32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 2'b00, 1'b0);
         step();
      end
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b want 0", in_ready); end
      vectors++;
      if (usage !== 4'd8) begin miscompares++; $display("FAIL fill_usage got %0d want 8", usage); end
      in_entry = mk(32'h100, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0);
      step();
      vectors++;
      if (usage !== 4'd8) begin miscompares++; $display("FAIL fill_ninth_usage got %0d want 8", usage); end
      // Full with a simultaneous pop: the push must be refused.
      in_entry = mk(32'h200, 32'hBAD0_0000, 1'b0, 2'b00, 1'b0);
      fetch_ack = 1'b1;
      vectors++;
      if (fetch_entry.address !== 32'h0) begin miscompares++; $display("FAIL fill_head0 got %h want 0", fetch_entry.address); end
      step();
      in_valid = 1'b0;
      fetch_ack = 1'b0;
      vectors++;
      if (usage !== 4'd7) begin miscompares++; $display("FAIL fill_full_pop_usage got %0d want 7", usage); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_again got %b want 1", in_ready); end
      for (int i = 1; i < DEPTH; i++) begin
         vectors++;
         if (fetch_entry.address !== 32'(4 * i) || fetch_entry.instruction !== 32'hA000_0000 + 32'(i)) begin
            miscompares++;
            $display("FAIL fill_order[%0d] got %h want addr %h", i, fetch_entry, 32'(4 * i));
         end
         fetch_ack = 1'b1;
         step();
         fetch_ack = 1'b0;
      end
      vectors++;
      if (usage !== 4'd0 || fetch_valid !== 1'b0) begin
         miscompares++; $display("FAIL fill_drain got usage %0d valid %b want 0 0", usage, fetch_valid);
      end
   endtask

   task automatic test_push_pop();
      for (int n = 0; n < 3; n++) begin
         in_valid = 1'b1;
         in_entry = mk(32'h1000 + 32'(4 * n), 32'(n), 1'b0, 2'b00, 1'b0);
         step();
      end
      for (int k = 0; k < 20; k++) begin
         in_valid  = 1'b1;
         fetch_ack = 1'b1;
         in_entry  = mk(32'h1000 + 32'(4 * (k + 3)), 32'(k + 3), 1'b0, 2'b00, 1'b0);
         vectors++;
         if (fetch_entry.address !== 32'h1000 + 32'(4 * k)) begin
            miscompares++; $display("FAIL pp_head[%0d] got %h want %h", k, fetch_entry.address, 32'h1000 + 32'(4 * k));
         end
         step();
         vectors++;
         if (usage !== 4'd3) begin miscompares++; $display("FAIL pp_usage[%0d] got %0d want 3", k, usage); end
      end
      in_valid = 1'b0;
      for (int k = 20; k < 23; k++) begin
         fetch_ack = 1'b1;
         vectors++;
         if (fetch_entry.address !== 32'h1000 + 32'(4 * k)) begin
            miscompares++; $display("FAIL pp_drain[%0d] got %h want %h", k, fetch_entry.address, 32'h1000 + 32'(4 * k));
         end
         step();
      end
      fetch_ack = 1'b0;
      vectors++;
      if (usage !== 4'd0) begin miscompares++; $display("FAIL pp_empty got %0d want 0", usage); end
   endtask

   task automatic test_flush();
      frontend_fetch_t x;
      for (int n = 0; n < 5; n++) begin
         in_valid = 1'b1;
         in_entry = mk(32'h2000 + 32'(4 * n), 32'(n), 1'b0, 2'b00, 1'b0);
         step();
      end
      vectors++;
      if (usage !== 4'd5) begin miscompares++; $display("FAIL flush_pre_usage got %0d want 5", usage); end
      flush = 1'b1; fetch_ack = 1'b1;
      in_entry = mk(32'h2FFC, 32'hFFFF_FFFF, 1'b1, 2'b11, 1'b1);
      step();
      flush = 1'b0; fetch_ack = 1'b0; in_valid = 1'b0;
      vectors++;
      if (usage !== 4'd0) begin miscompares++; $display("FAIL flush_usage got %0d want 0", usage); end
      vectors++;
      if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", fetch_valid); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", in_ready); end
      x = mk(32'h3000, 32'h1234_5678, 1'b0, 2'b01, 1'b0);
      in_valid = 1'b1; in_entry = x;
      step();
      in_valid = 1'b0;
      vectors++;
      if (fetch_entry !== x || usage !== 4'd1) begin
         miscompares++; $display("FAIL flush_next got %h usage %0d want %h usage 1", fetch_entry, usage, x);
      end
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
   endtask

   task automatic test_backpressure();
      frontend_fetch_t b;
      b = mk(32'h4000_0040, 32'hFEDC_BA98, 1'b1, 2'b10, 1'b1);
      in_valid = 1'b1; in_entry = b;
      step();
      in_valid = 1'b0;
      in_entry = mk(32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (fetch_entry !== b || fetch_valid !== 1'b1) begin
            miscompares++; $display("FAIL bp_hold[%0d] got %h valid %b want %h", k, fetch_entry, fetch_valid, b);
         end
         step();
      end
      vectors++;
      if (fetch_entry.page_fault !== 1'b1 || fetch_entry.branch_taken !== 2'b10) begin
         miscompares++; $display("FAIL bp_fields got pf %b bt %b want 1 10", fetch_entry.page_fault, fetch_entry.branch_taken);
      end
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      frontend_fetch_t e;
      for (int n = 0; n < 4; n++) begin
         in_valid = 1'b1;
         in_entry = mk(32'h5000 + 32'(4 * n), 32'(n), 1'b0, 2'b00, 1'b0);
         step();
      end
      in_valid = 1'b0;
      vectors++;
      if (usage !== 4'd4) begin miscompares++; $display("FAIL rmid_pre_usage got %0d want 4", usage); end
      rst = 1'b1;
      #1;
      vectors++;
      if (usage !== 4'd0 || fetch_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++; $display("FAIL rmid_async got usage %0d valid %b ready %b want 0 0 1", usage, fetch_valid, in_ready);
      end
      #2;
      rst = 1'b0;
      e = mk(32'h6000, 32'hCAFE_F00D, 1'b1, 2'b01, 1'b0);
      step();
      in_valid = 1'b1; in_entry = e;
      step();
      in_valid = 1'b0;
      vectors++;
      if (fetch_entry !== e || usage !== 4'd1) begin
         miscompares++; $display("FAIL rmid_next got %h usage %0d want %h usage 1", fetch_entry, usage, e);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_push_pop();
      test_flush();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
